// File: rtl/data_bus_bridge.sv
// Registered bridge from a core data-memory port to a valid/ready request, response-capture bus.
// Define DATA_BUS_TIMEOUT_EN to bound the response wait to TIMEOUT_CYCLES and flag bus_error.
module data_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] bus_address,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   output logic [31:0] bus_read_data,
   output logic        bus_stall,
   output logic        bus_error,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_write,
   output logic [31:0] mem_req_address,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_byte_enable,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        write_q, write_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bus_req;

`ifdef DATA_BUS_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            error_q, error_d;
`endif

   assign bus_req = bus_read_enable | bus_write_enable;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      write_d = write_q;
      rdata_d = rdata_q;
`ifdef DATA_BUS_TIMEOUT_EN
      cnt_d   = cnt_q;
      error_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus_req) begin
               addr_d  = {bus_address[31:2], 2'b00};
               wdata_d = bus_write_data;
               // Write wins when both enables are high; loads always fetch the full word.
               be_d    = bus_write_enable ? bus_byte_enable : 4'b1111;
               write_d = bus_write_enable;
               state_d = StReq;
            end
         end
         StReq: begin
            if (mem_req_ready) begin
               state_d = write_q ? StDone : StResp;
`ifdef DATA_BUS_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         StResp: begin
            if (mem_rsp_valid) begin
               rdata_d = mem_rsp_data;
               state_d = StDone;
            end
`ifdef DATA_BUS_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = 32'hDEAD_BEEF;
               error_d = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef DATA_BUS_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         error_q <= error_d;
      end
   end

   // error_q is set only on the timeout transition, so it is high for exactly the DONE cycle.
   assign bus_error = error_q;
`else
   assign bus_error = 1'b0;
`endif

   assign mem_req_valid       = (state_q == StReq);
   assign mem_req_write       = write_q;
   assign mem_req_address     = addr_q;
   assign mem_req_wdata       = wdata_q;
   assign mem_req_byte_enable = be_q;
   assign bus_read_data       = rdata_q;
   assign bus_stall           = bus_req & (state_q != StDone);

endmodule
